// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths, constants and prescaler sizing for the PWM peripheral
package pwm_pkg;

  localparam int         PWM_CNT_W       = 8;
  localparam int         PWM_OUT_W       = 16;
  localparam logic [7:0] DUTY_FULL       = 8'hFF;
  localparam int         CLK_DIV_DEFAULT = 3000;

  // Prescaler register width; a divide-by-1 still needs a 1-bit register.
  function automatic int presc_width(input int clk_div);
    int w;
    w = $clog2(clk_div);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - clock prescaler, 8-bit period counter and period_start pulse
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 o_tick,
  output logic [PWM_CNT_W-1:0] o_pwm_cnt,
  output logic                 o_wrap,
  output logic                 o_period_start
);

  localparam int            PW         = presc_width(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]        r_presc;
  logic [PWM_CNT_W-1:0] r_pwm_cnt;
  logic                 r_first;
  logic                 r_period_start;
  logic                 w_tick;
  logic                 w_wrap;

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_wrap = w_tick && (r_pwm_cnt == {PWM_CNT_W{1'b1}});

  // Prescaler: count 0..CLK_DIV-1 and wrap, one tick per wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Period counter advances on each tick; 255 -> 0 wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // period_start pulses after the wrapping tick, and once on the first clk out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first        <= 1'b1;
      r_period_start <= 1'b0;
    end else begin
      r_first        <= 1'b0;
      r_period_start <= w_wrap | r_first;
    end
  end

  assign o_tick         = w_tick;
  assign o_pwm_cnt      = r_pwm_cnt;
  assign o_wrap         = w_wrap;
  assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-pin PWM driver; PWM_DUTY_SHADOW_EN latches duty once per period
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [7:0]           pwm_duty_cycle,
  output logic [PWM_OUT_W-1:0] out,
  output logic                 period_start
);

  logic                 w_tick;
  logic                 w_wrap;
  logic [PWM_CNT_W-1:0] w_pwm_cnt;
  logic [7:0]           w_duty_eff;
  logic                 w_pwm_sig;
  logic [PWM_OUT_W-1:0] w_en_out;
  logic [PWM_OUT_W-1:0] w_en_pwm;
  logic [PWM_OUT_W-1:0] r_out;
  logic                 w_unused;

  pwm_timebase #(
    .CLK_DIV(CLK_DIV)
  ) u_timebase (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_tick        (w_tick),
    .o_pwm_cnt     (w_pwm_cnt),
    .o_wrap        (w_wrap),
    .o_period_start(period_start)
  );

`ifdef PWM_DUTY_SHADOW_EN
  logic       r_init;
  logic [7:0] r_duty_sh;

  // Duty shadow reloads at the period boundary and once right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init    <= 1'b1;
      r_duty_sh <= '0;
    end else begin
      r_init <= 1'b0;
      if (r_init || w_wrap) begin
        r_duty_sh <= pwm_duty_cycle;
      end
    end
  end

  assign w_duty_eff = r_duty_sh;
  assign w_unused   = &{1'b0, w_tick};
`else
  assign w_duty_eff = pwm_duty_cycle;
  assign w_unused   = &{1'b0, w_tick, w_wrap};
`endif

  // Full-scale duty is a constant high rather than 255/256.
  assign w_pwm_sig = (w_duty_eff == DUTY_FULL) || (w_pwm_cnt < w_duty_eff);

  assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Per-pin select: disabled -> 0, static -> 1, PWM mode -> shared waveform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_en_out & (~w_en_pwm | {PWM_OUT_W{w_pwm_sig}});
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - randomized self-checking bench for pwm_peripheral against a period/time model
module tb_pwm_peripheral;

  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 256 * CLK_DIV;

  logic        clk;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  int          checks   = 0;
  int          failures = 0;
  int          n_edge   = 0;
  logic [7:0]  m_shadow = 8'h00;
  logic [15:0] exp_out  = 16'h0000;
  logic        exp_ps   = 1'b0;
  int          hi_cnt   = 0;
  int          ps_cnt   = 0;

  pwm_peripheral #(
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .out            (out),
    .period_start   (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n_edge   = 0;
    m_shadow = 8'h00;
    exp_out  = 16'h0000;
    exp_ps   = 1'b0;
  endtask

  // Model one rising edge: the n-th clk after release sees counter floor((n-1)/CLK_DIV) mod 256,
  // and period boundaries fall on every multiple of 256*CLK_DIV edges.
  task automatic model_edge();
    int          cnt;
    logic [7:0]  duty;
    logic        sig;
    logic [15:0] en_o;
    logic [15:0] en_p;
    if (!rst_n) begin
      model_reset();
    end else begin
      n_edge++;
      cnt = ((n_edge - 1) / CLK_DIV) % 256;
`ifdef PWM_DUTY_SHADOW_EN
      duty = m_shadow;
`else
      duty = pwm_duty_cycle;
`endif
      sig     = (duty == 8'hFF) || (cnt < int'(duty));
      en_o    = {en_reg_out_15_8, en_reg_out_7_0};
      en_p    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      exp_out = 16'h0000;
      for (int i = 0; i < 16; i++) begin
        if (en_o[i]) exp_out[i] = en_p[i] ? sig : 1'b1;
      end
      exp_ps = (n_edge == 1) || (n_edge % PERIOD == 0);
      if ((n_edge == 1) || (n_edge % PERIOD == 0)) m_shadow = pwm_duty_cycle;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("out", {16'h0, out}, {16'h0, exp_out});
    check("period_start", {31'h0, period_start}, {31'h0, exp_ps});
    if (out == 16'hFFFF) hi_cnt++;
    if (period_start) ps_cnt++;
  endtask

  task automatic wait_ps();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < PERIOD + 8; k++) begin
      step();
      if (period_start) begin
        seen = 1'b1;
        break;
      end
    end
    check("ps_timeout", {31'h0, seen}, 32'd1);
  endtask

  task automatic set_all(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    pwm_duty_cycle = d;
  endtask

  logic [7:0] bnd_duty [3] = '{8'h00, 8'hFF, 8'h01};
  int         bnd_hi   [3] = '{0, PERIOD, CLK_DIV};

  initial begin
    rst_n = 1'b0;
    set_all(16'hFFFF, 16'h0000, 8'h00);
    model_reset();
    repeat (3) step();
    check("reset_out", {16'h0, out}, 32'h0);

    rst_n = 1'b1;
    step();
    check("release_out", {16'h0, out}, 32'hFFFF);

    set_all(16'h00FF, 16'h0000, 8'h00);
    step();
    check("en_lo", {16'h0, out}, 32'h00FF);
    en_reg_out_15_8 = 8'h01;
    step();
    check("en_toggle", {16'h0, out}, 32'h01FF);

    set_all(16'hFFFF, 16'hFFFF, 8'h80);
    wait_ps();
    hi_cnt = 0;
    ps_cnt = 0;
    repeat (PERIOD) step();
    check("half_high", hi_cnt, PERIOD / 2);
    check("ps_per_period", ps_cnt, 1);

    for (int b = 0; b < 3; b++) begin
      pwm_duty_cycle = bnd_duty[b];
      wait_ps();
      hi_cnt = 0;
      repeat (PERIOD) step();
      check("duty_bound", hi_cnt, bnd_hi[b]);
    end

    pwm_duty_cycle = 8'h40;
    wait_ps();
    repeat (8'h50 * CLK_DIV) step();
    pwm_duty_cycle = 8'hC0;
    step();
`ifdef PWM_DUTY_SHADOW_EN
    check("mid_change", {16'h0, out}, 32'h0000);
`else
    check("mid_change", {16'h0, out}, 32'hFFFF);
`endif
    wait_ps();
    hi_cnt = 0;
    repeat (PERIOD) step();
    check("after_change", hi_cnt, (PERIOD * 3) / 4);

    wait_ps();
    repeat (8'h90 * CLK_DIV) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_out", {16'h0, out}, 32'h0);
    check("async_rst_ps", {31'h0, period_start}, 32'h0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_ps_once", {31'h0, period_start}, 32'd1);
    step();
    check("rst_ps_clear", {31'h0, period_start}, 32'd0);

    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 49) == 0) en_reg_out_7_0  = 8'($urandom);
      if ($urandom_range(0, 49) == 0) en_reg_out_15_8 = 8'($urandom);
      if ($urandom_range(0, 49) == 0) en_reg_pwm_7_0  = 8'($urandom);
      if ($urandom_range(0, 49) == 0) en_reg_pwm_15_8 = 8'($urandom);
      if ($urandom_range(0, 99) == 0) pwm_duty_cycle  = 8'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five configuration registers produced by the SPI register block and drives 16 output pins.
- Each pin is forced low, forced high, or driven by a shared 8-bit PWM waveform.
- Internal timebase: a clock prescaler feeding an 8-bit period counter.
- Sits directly downstream of the SPI register block; its outputs go straight to the chip's output pads.

Parameters:
- CLK_DIV, 3000: clk cycles per PWM counter tick. Legal range >= 1. At clk = 10 MHz, PWM frequency is about 13 Hz × (3000/CLK_DIV)… formula: f_pwm = f_clk / (256 × CLK_DIV).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- en_reg_out_7_0  input  8  output enable, pins 7..0
- en_reg_out_15_8  input  8  output enable, pins 15..8
- en_reg_pwm_7_0  input  8  PWM-mode select, pins 7..0
- en_reg_pwm_15_8  input  8  PWM-mode select, pins 15..8
- pwm_duty_cycle  input  8  duty value, 0x00..0xFF
- out  output  16  pin drive; out[15:8] maps to the *_15_8 registers, out[7:0] to *_7_0
- period_start  output  1  one-clk pulse at the start of each PWM period

Behaviour:
- Reset (already decided): rst_n asynchronous, active-low; clock clk.
- Values held in reset: out=0, period_start=0, prescaler=0, pwm_cnt=0, duty shadow=0.
- Inputs: all are synchronous to clk (same domain as the SPI block registers), so there are no synchronisers.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - tick is asserted when the prescaler equals CLK_DIV-1.
  - With CLK_DIV=1, tick is asserted every cycle.
- pwm_cnt: 8-bit, increments on tick, wraps 255 -> 0 naturally.
- period_start:
  - Registered; asserted for exactly one clk in the cycle after the tick that wraps pwm_cnt 255 -> 0.
  - Also asserted once on the first clk after reset release.
- PWM waveform: pwm_sig = (pwm_cnt < duty_eff), except duty_eff = 0xFF gives pwm_sig = 1 constantly.
  - duty 0x00: always low.
  - duty 0x80: high for 128 of 256 ticks.
  - duty 0xFE: high for 254 of 256 ticks.
- Per-pin select, for bit i with e = en_out[i] and p = en_pwm[i]:
  - e=0: out[i]=0, regardless of p.
  - e=1, p=0: out[i]=1.
  - e=1, p=1: out[i]=pwm_sig.
- Latency:
  - out is registered.
  - An enable or mode change appears on out exactly 1 clk after the input changes.
  - A duty change follows the Optional Feature rules.
- All PWM pins share one counter, so they are phase-aligned and rise together at pwm_cnt=0 when duty>0.
- Reset mid-period: counters and out clear immediately (asynchronous). After release, counting restarts at pwm_cnt=0 with prescaler=0.
- Simultaneous duty change and counter wrap: the wrap tick uses the old duty for the comparison; the new duty applies from the next evaluated cycle (shadowed or not).
- No glitches: out changes only on clk edges.

Optional Feature:
- Macro: PWM_DUTY_SHADOW_EN.
- Defined:
  - pwm_duty_cycle is copied into a shadow register only on the cycle where tick is asserted and pwm_cnt==255, and on the first cycle after reset.
  - The comparison uses the shadow, so the duty is constant within a period and no truncated or double pulses occur.
- Undefined:
  - The comparison uses the live pwm_duty_cycle every cycle.
  - A mid-period change takes effect on out 1 clk later.
- Enables are never shadowed in either case.

Decomposition:
- Package pwm_pkg:
  - PWM_CNT_W=8, PWM_OUT_W=16, DUTY_FULL=8'hFF, CLK_DIV_DEFAULT=3000.
  - A function computing the prescaler width as $clog2(CLK_DIV), minimum 1.
- Sub-module pwm_timebase:
  - Contains the prescaler, pwm_cnt and period_start generation.
  - Outputs tick, pwm_cnt and wrap.
- Top level: duty shadow, compare and per-pin mux/register.

Test Plan:
- Reset with CLK_DIV=4, all enables 0xFF, PWM mode 0x00 -> out=0x0000 during reset; out=0xFFFF 1 clk after release.
- en_out=0x00FF, en_pwm=0x0000 -> out=0x00FF; then toggle en_out_15_8=0x01 -> out=0x01FF exactly 1 clk later.
- CLK_DIV=4, all pins PWM-enabled:
  - duty=0x80 -> each period is 1024 clk; out=0xFFFF for 512 clk and 0x0000 for 512 clk.
  - period_start pulses every 1024 clk.
- Duty boundaries: 0x00 -> out constant 0x0000; 0xFF -> constant 0xFFFF; 0x01 -> high for 4 clk per 1024.
- Mid-period duty change 0x40 -> 0xC0 at pwm_cnt=0x50:
  - With PWM_DUTY_SHADOW_EN: the current period stays low (0x50 >= 0x40); the next period is high for 768 clk.
  - Without the macro: out rises 1 clk after the change.
- Assert rst_n low at pwm_cnt=0x90 -> out=0 immediately; after release, the first high pulse starts at pwm_cnt=0 and period_start pulses once.
